// File: rtl/conv_stream_feeder.sv
// Host-side feeder for the convolution accelerator: replays a word buffer with
// header/kernel/stream load timing, then collects the 32-bit result stream.
module conv_stream_feeder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RES_DEPTH  = 16,
  parameter int unsigned HDR_CYCLES = 3,
  parameter int unsigned KER_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH)-1:0]       wr_addr,
  input  logic [127:0]                   wr_data,
  input  logic [$clog2(DEPTH):0]         num_words,
  input  logic [$clog2(RES_DEPTH):0]     exp_results,
  input  logic                           start,
  output logic                           control,
  output logic [127:0]                   data_in,
  input  logic                           acc_valid,
  input  logic                           acc_done,
  input  logic [31:0]                    acc_data,
  output logic                           busy,
  output logic                           finished,
  output logic                           err,
  output logic [$clog2(RES_DEPTH):0]     res_count,
  input  logic [$clog2(RES_DEPTH)-1:0]   res_rd_addr,
  output logic [31:0]                    res_rd_data
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned NW  = AW + 1;
  localparam int unsigned RAW = $clog2(RES_DEPTH);
  localparam int unsigned RCW = RAW + 1;
  localparam int unsigned PW  = 8;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_KER, S_STREAM, S_COLLECT, S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [NW-1:0]    widx_q, widx_d;
  logic [NW-1:0]    nw_q, nw_d;
  logic [RCW-1:0]   exp_q, exp_d;
  logic [RCW-1:0]   res_cnt_q, res_cnt_d;
  logic [TW-1:0]    idle_q, idle_d;
  logic             err_q, err_d;
  logic             control_q, control_d;
  logic [127:0]     data_in_q, data_in_d;
  logic             busy_q, busy_d;
  logic             finished_q, finished_d;
  logic [31:0]      res_rd_data_q;
  logic             cap_we;
  logic [NW-1:0]    widx_nxt;

  logic [127:0]     word_mem [DEPTH];
  logic [31:0]      res_mem  [RES_DEPTH];

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    widx_d     = widx_q;
    nw_d       = nw_q;
    exp_d      = exp_q;
    res_cnt_d  = res_cnt_q;
    idle_d     = idle_q;
    err_d      = err_q;
    control_d  = control_q;
    data_in_d  = data_in_q;
    cap_we     = 1'b0;
    widx_nxt   = widx_q + NW'(1);

    // Capture runs in every active state; a full buffer drops and flags.
    if (state_q != S_IDLE && acc_valid) begin
      if (res_cnt_q == RCW'(RES_DEPTH)) begin
        err_d = 1'b1;
      end else begin
        cap_we    = 1'b1;
        res_cnt_d = res_cnt_q + RCW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nw_d      = num_words;
          exp_d     = exp_results;
          res_cnt_d = '0;
          ph_d      = '0;
          if (num_words < NW'(2) || num_words > NW'(DEPTH)) begin
            err_d     = 1'b1;
            state_d   = S_FIN;
            control_d = 1'b0;
            data_in_d = '0;
          end else begin
            err_d     = 1'b0;
            state_d   = S_HDR;
            control_d = 1'b1;
            data_in_d = word_mem[AW'(0)];
          end
        end
      end
      S_HDR: begin
        if (ph_q == PW'(HDR_CYCLES - 1)) begin
          ph_d      = '0;
          state_d   = S_KER;
          data_in_d = word_mem[AW'(1)];
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_KER: begin
        if (ph_q == PW'(KER_CYCLES - 1)) begin
          ph_d = '0;
          if (nw_q == NW'(2)) begin
            state_d = S_COLLECT;
            idle_d  = '0;
          end else begin
            state_d   = S_STREAM;
            widx_d    = NW'(2);
            data_in_d = word_mem[AW'(2)];
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_STREAM: begin
        if (widx_q == nw_q - NW'(1)) begin
          state_d = S_COLLECT;
          idle_d  = '0;
        end else begin
          widx_d    = widx_nxt;
          data_in_d = word_mem[widx_nxt[AW-1:0]];
        end
      end
      S_COLLECT: begin
        idle_d = acc_valid ? '0 : idle_q + TW'(1);
        // Post-capture count is used so the final result exits on its own edge.
        if (res_cnt_d == exp_q || acc_done) begin
          state_d   = S_FIN;
          control_d = 1'b0;
          data_in_d = '0;
        end else if (!acc_valid && (idle_q + TW'(1)) == TW'(TIMEOUT)) begin
          state_d   = S_FIN;
          control_d = 1'b0;
          data_in_d = '0;
          err_d     = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        control_d = 1'b0;
        data_in_d = '0;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    finished_d = (state_q == S_FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ph_q          <= '0;
      widx_q        <= '0;
      nw_q          <= '0;
      exp_q         <= '0;
      res_cnt_q     <= '0;
      idle_q        <= '0;
      err_q         <= 1'b0;
      control_q     <= 1'b0;
      data_in_q     <= '0;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      res_rd_data_q <= '0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      widx_q        <= widx_d;
      nw_q          <= nw_d;
      exp_q         <= exp_d;
      res_cnt_q     <= res_cnt_d;
      idle_q        <= idle_d;
      err_q         <= err_d;
      control_q     <= control_d;
      data_in_q     <= data_in_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
      res_rd_data_q <= res_mem[res_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE) begin
      word_mem[wr_addr] <= wr_data;
    end
    if (cap_we) begin
      res_mem[res_cnt_q[RAW-1:0]] <= acc_data;
    end
  end

  assign control     = control_q;
  assign data_in     = data_in_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign err         = err_q;
  assign res_count   = res_cnt_q;
  assign res_rd_data = res_rd_data_q;

endmodule
